// File: rtl/max_event_logger.sv
// Event logger for the terminal-state pulse of an upstream 4-state FSM.
// Timestamps rising edges of i_max into a show-ahead FIFO with statistics.
module max_event_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_max,
  input  logic [1:0]      i_state,
  input  logic            i_clr,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [TS_W-1:0] o_data,
  output logic [7:0]      o_count,
  output logic            o_overflow,
  output logic            o_seq_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [TS_W-1:0] ts;
  logic            max_d;
  logic [1:0]      prev_state;

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     occ;

  logic            evt;
  logic            push;
  logic            pop;
  logic            full;
  logic            accept;
  logic            drop;
  logic [1:0]      next_legal;
  logic            seq_bad;

  // Event detection, FIFO handshake and sequence check
  always_comb begin
    evt        = i_max & ~max_d;
    full       = (occ == OCC_FULL);
    push       = evt & ~i_clr;
    pop        = o_valid & i_ready & ~i_clr;
    accept     = push & (~full | pop);
    drop       = push & full & ~pop;
    next_legal = prev_state + 2'd1;
    seq_bad    = (i_state != prev_state) &&
                 (i_state != next_legal);
  end

  // Free-running timestamp, unaffected by clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Edge history of i_max and of the upstream state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      max_d      <= 1'b0;
      prev_state <= 2'd0;
    end else begin
      max_d      <= i_max;
      prev_state <= i_state;
    end
  end

  // Storage array; head slot may be rewritten as it is popped
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[wr_ptr] <= ts;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({accept, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Saturating event count, counts dropped events too
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (evt && o_count != 8'hff) begin
      o_count <= o_count + 8'd1;
    end
  end

  // Sticky overflow and sequence-error flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
      o_seq_err  <= 1'b0;
    end else if (i_clr) begin
      o_overflow <= 1'b0;
      o_seq_err  <= 1'b0;
    end else begin
      if (drop)    o_overflow <= 1'b1;
      if (seq_bad) o_seq_err  <= 1'b1;
    end
  end

  // Show-ahead head, forced to zero when empty
  always_comb begin
    o_valid = (occ != '0);
    o_data  = o_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_max_event_logger.sv
// Scoreboard bench for max_event_logger.
// Stimulus queues expected timestamps; a monitor checks every pop.
module tb_max_event_logger;

  localparam int TS_W  = 8;
  localparam int DEPTH = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_max;
  logic [1:0]      i_state;
  logic            i_clr;
  logic            i_ready;
  logic            o_valid;
  logic [TS_W-1:0] o_data;
  logic [7:0]      o_count;
  logic            o_overflow;
  logic            o_seq_err;

  int errors = 0;
  int checks = 0;

  logic [TS_W-1:0] q[$];
  logic [TS_W-1:0] mts;
  logic            lastm = 1'b0;
  int              ecnt  = 0;

  max_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_max      (i_max),
    .i_state    (i_state),
    .i_clr      (i_clr),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_seq_err  (o_seq_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mts <= '0;
    else          mts <= mts + 8'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready && !i_clr) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("pop_data", int'(o_data), int'(q.pop_front()));
      end
    end
  end

  task automatic drive(input logic mx, input logic [1:0] st,
                       input logic rd, input logic cl);
    i_max   = mx;
    i_state = st;
    i_ready = rd;
    i_clr   = cl;
    if (cl) begin
      q.delete();
      ecnt = 0;
    end else if (mx && !lastm) begin
      if (ecnt != 255) ecnt++;
      if (q.size() < DEPTH || (rd && q.size() > 0)) q.push_back(mts);
    end
    lastm = mx;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_data"},  int'(o_data), 0);
    chk({tag, "_count"}, int'(o_count), 0);
    chk({tag, "_ovf"},   int'(o_overflow), 0);
    chk({tag, "_seq"},   int'(o_seq_err), 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_max   = 1'b0;
    i_state = 2'd0;
    i_clr   = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_zero("reset");
    i_rst_n = 1'b1;

    // basic event at timestamp 3
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 2, 0, 0);
    drive(1, 3, 0, 0);
    chk("basic_valid", int'(o_valid), 1);
    chk("basic_data", int'(o_data), 3);
    chk("basic_count", int'(o_count), 1);
    chk("basic_ovf", int'(o_overflow), 0);
    chk("basic_seq", int'(o_seq_err), 0);

    // held i_max gives one event
    drive(0, 3, 0, 0);
    repeat (3) drive(1, 3, 0, 0);
    drive(0, 3, 0, 0);
    chk("held_count", int'(o_count), 2);
    repeat (3) drive(0, 3, 1, 0);
    chk("drain_valid", int'(o_valid), 0);
    chk("drain_data", int'(o_data), 0);

    // overflow: five events, four stored
    repeat (5) begin
      drive(1, 3, 0, 0);
      drive(0, 3, 0, 0);
    end
    chk("ovf_flag", int'(o_overflow), 1);
    chk("ovf_count", int'(o_count), 7);
    chk("ovf_valid", int'(o_valid), 1);
    repeat (6) drive(0, 3, 1, 0);
    chk("ovf_empty_valid", int'(o_valid), 0);
    chk("ovf_empty_data", int'(o_data), 0);
    chk("ovf_sticky", int'(o_overflow), 1);

    // clear coincident with an event
    drive(1, 3, 0, 1);
    chk_zero("clr");
    drive(0, 3, 0, 0);
    chk("clr_nocount", int'(o_count), 0);

    // full FIFO with simultaneous push and pop
    repeat (4) begin
      drive(1, 3, 0, 0);
      drive(0, 3, 0, 0);
    end
    drive(1, 3, 1, 0);
    drive(0, 3, 0, 0);
    chk("pp_ovf", int'(o_overflow), 0);
    chk("pp_count", int'(o_count), 5);
    chk("pp_valid", int'(o_valid), 1);
    repeat (4) drive(0, 3, 1, 0);
    chk("pp_empty", int'(o_valid), 0);

    // sequence checking
    drive(0, 0, 0, 0);
    chk("seq_3to0", int'(o_seq_err), 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("seq_1to1", int'(o_seq_err), 0);
    drive(0, 2, 0, 0);
    drive(0, 3, 0, 0);
    drive(0, 0, 0, 0);
    chk("seq_legal", int'(o_seq_err), 0);
    drive(0, 2, 0, 0);
    chk("seq_0to2", int'(o_seq_err), 1);
    drive(0, 2, 0, 0);
    chk("seq_sticky", int'(o_seq_err), 1);
    drive(0, 2, 0, 1);
    chk("seq_clr", int'(o_seq_err), 0);

    // count saturation with timestamp wrap
    drive(0, 3, 1, 0);
    repeat (260) begin
      drive(1, 3, 1, 0);
      drive(0, 3, 1, 0);
    end
    chk("sat_count", int'(o_count), 255);
    chk("sat_ovf", int'(o_overflow), 0);

    // asynchronous reset mid-burst
    drive(1, 3, 0, 0);
    drive(0, 3, 0, 0);
    drive(1, 3, 0, 0);
    chk("pre_rst_valid", int'(o_valid), 1);
    #2;
    i_rst_n = 1'b0;
    q.delete();
    ecnt  = 0;
    lastm = 1'b0;
    #1;
    chk_zero("async_rst");
    i_max   = 1'b0;
    i_state = 2'd0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    drive(1, 0, 0, 0);
    chk("post_rst_valid", int'(o_valid), 1);
    chk("post_rst_data", int'(o_data), 0);
    chk("post_rst_count", int'(o_count), 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("post_rst_empty", int'(o_valid), 0);
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/max_event_logger.md
MAX_EVENT_LOGGER -- requirements
Module: max_event_logger

Interface
REQ-001 The block SHALL have parameter TS_W, default 8, meaning timestamp width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning event FIFO depth (power of two, at least 2).
REQ-003 The block SHALL have port i_clk  input  1  meaning the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port i_max  input  1  meaning the terminal-state flag from the upstream 4-state counter FSM.
REQ-006 The block SHALL have port i_state  input  2  meaning the current state of the upstream FSM (A=0, B=1, C=2, D=3).
REQ-007 The block SHALL have port i_clr  input  1  meaning a synchronous clear of the statistics and the FIFO.
REQ-008 The block SHALL have port i_ready  input  1  meaning the consumer accepts the FIFO head.
REQ-009 The block SHALL have port o_valid  output  1  meaning the FIFO holds at least one entry.
REQ-010 The block SHALL have port o_data  output  TS_W  meaning the timestamp at the FIFO head.
REQ-011 The block SHALL have port o_count  output  8  meaning the saturating total count of events.
REQ-012 The block SHALL have port o_overflow  output  1  meaning a sticky flag indicating an event was dropped.
REQ-013 The block SHALL have port o_seq_err  output  1  meaning a sticky flag indicating an illegal i_state transition.

Function
REQ-014 The block SHALL increment a free-running TS_W-bit timestamp counter every cycle, wrapping from 2^TS_W-1 to 0; i_clr SHALL NOT affect it.
REQ-015 The block SHALL register i_max into max_d; an event occurs on an edge where i_max=1 and max_d=0, so i_max held high for N cycles yields exactly one event.
REQ-016 On an event edge, the block SHALL push the timestamp value present before that edge's increment.
REQ-017 The FIFO SHALL be show-ahead: o_valid=(occupancy>0), o_data=head entry when o_valid=1, and o_data=0 when the FIFO is empty.
REQ-018 A pop SHALL occur on an edge where o_valid=1 and i_ready=1; i_ready while empty SHALL have no effect.
REQ-019 Latency: o_valid/o_data SHALL reflect a push into an empty FIFO in the cycle immediately after the event edge.
REQ-020 A push and pop on the same edge SHALL leave occupancy unchanged, including when the FIFO is full; in that case the push is accepted and o_overflow is not set.
REQ-021 A push when the FIFO is full with no pop SHALL be dropped and SHALL set o_overflow, which holds until i_clr or reset.
REQ-022 o_count SHALL increment on every event (accepted or dropped) and saturate at 255.
REQ-023 The block SHALL track prev_state; an edge where i_state differs from both prev_state and (prev_state+1) mod 4 SHALL set o_seq_err (sticky); prev_state then takes i_state.
REQ-024 i_clr=1 SHALL, on that edge, empty the FIFO and zero o_count, o_overflow and o_seq_err, with priority over any coincident event, pop or sequence error (the event is neither stored nor counted).
REQ-025 max_d and prev_state SHALL still update normally during i_clr.

Reset
REQ-026 i_rst_n=0 SHALL immediately and asynchronously clear the timestamp, max_d, FIFO pointers and occupancy, o_count, o_overflow and o_seq_err, and set prev_state=A.
REQ-027 During reset, outputs SHALL be o_valid=0, o_data=0, o_count=0, o_overflow=0 and o_seq_err=0; reset asserted mid-operation SHALL discard all stored entries.
REQ-028 After i_rst_n rises, the first rising clock edge SHALL be fully functional (timestamp 0 to 1).

Verification
REQ-029 Basic event: release reset; drive i_state 0,1,2,3 on successive edges with i_max=1 only while state=3 (timestamp 3), i_ready=0 -> next cycle o_valid=1, o_data=3, o_count=1, no flags.
REQ-030 Held input: i_max high for 3 cycles -> exactly one entry; o_count +1.
REQ-031 Overflow: 5 events with i_ready=0 -> 4 entries stored, o_overflow=1, o_count=5; then i_ready=1 -> the 4 oldest timestamps appear in order, then o_valid=0 and o_data=0.
REQ-032 Full FIFO with simultaneous push and pop -> occupancy remains 4, head advances, newest timestamp is stored, o_overflow stays 0.
REQ-033 Sequence check: i_state 0 then 2 -> o_seq_err=1 after that edge; 3 then 0 and 1 then 1 -> no error.
REQ-034 Clear and reset: i_clr coincident with an event -> FIFO empty, o_count=0, flags 0; i_rst_n pulsed low mid-burst -> outputs 0 immediately, without waiting for a clock edge.
